// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with single-outstanding memory port
// Redirect flushes the queue; a response still in flight is dropped via the DROP state.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        out_valid,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [29:0]   fpc_q, fpc_d;
  logic [29:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [29:0] pc_mem  [DEPTH];
  logic [31:0] ins_mem [DEPTH];

  logic fire, enq, deq;
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // A request needs a free slot so its response can always be enqueued.
  assign im_req    = reset && (state_q == IDLE) && !redirect && (count_q < CW'(DEPTH));
  assign im_addr   = {fpc_q, 2'b00};
  assign fire      = im_req && im_gnt;
  assign out_valid = (count_q != '0);
  assign out_ins   = ins_mem[head_q];
  assign out_pc    = {pc_mem[head_q], 2'b00};
  assign enq       = (state_q == WAIT) && im_rvalid && !redirect;
  assign deq       = out_valid && out_ready && !redirect;

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;

    if (redirect) begin
      fpc_d   = redirect_pc[31:2];
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (state_q != IDLE) state_d = im_rvalid ? IDLE : DROP;
    end else begin
      case (state_q)
        IDLE: if (fire) state_d = WAIT;
        WAIT: if (im_rvalid) state_d = IDLE;
        DROP: if (im_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (fire) begin
        fpc_d    = fpc_q + 30'd1;
        req_pc_d = fpc_q;
      end
      if (enq) tail_d = tail_q + PW'(1);
      if (deq) head_d = head_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      fpc_q    <= RESET_PC[31:2];
      req_pc_q <= RESET_PC[31:2];
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail_q]  <= req_pc_q;
      ins_mem[tail_q] <= im_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;
  int grants;

  logic [63:0] sb [$];

  logic        gnt_en, resp_en, inject;
  logic [31:0] inject_data;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_gnt     (im_gnt),
    .im_rvalid  (im_rvalid),
    .im_rdata   (im_rdata),
    .out_valid  (out_valid),
    .out_ins    (out_ins),
    .out_pc     (out_pc),
    .out_ready  (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Memory model: one-cycle response after a grant, data derived from the address.
  initial begin
    logic        fire_s;
    logic [31:0] addr_s;
    im_gnt    = 1'b0;
    im_rvalid = 1'b0;
    im_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      fire_s = reset && im_req && im_gnt;
      addr_s = im_addr;
      @(posedge clk);
      #2;
      im_rvalid = (fire_s && resp_en) || inject;
      im_rdata  = inject ? inject_data : {16'hC0DE, addr_s[15:0]};
      im_gnt    = gnt_en;
    end
  end

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual pc=%h ins=%h expected none", out_pc, out_ins);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({out_pc, out_ins} !== e) begin
          failures++;
          $display("FAIL sb_entry actual pc=%h ins=%h expected pc=%h ins=%h",
                   out_pc, out_ins, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    gnt_en      = 1'b0;
    resp_en     = 1'b0;
    inject      = 1'b0;
    inject_data = 32'h0;

    repeat (3) tick();
    neg();
    chk("rst_im_req", {31'b0, im_req}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_im_addr", im_addr, 32'h3000);

    // first fetch after reset release
    tick(); reset = 1'b1; gnt_en = 1'b1;
    neg();
    chk("first_req", {31'b0, im_req}, 32'd1);
    chk("first_addr", im_addr, 32'h3000);
    tick(); gnt_en = 1'b0; inject = 1'b1; inject_data = 32'h2408_0001;
    sb.push_back({32'h3000, 32'h2408_0001});
    neg();
    chk("wait_req", {31'b0, im_req}, 32'd0);
    chk("wait_addr", im_addr, 32'h3004);
    tick(); inject = 1'b0;
    neg();
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_pc", out_pc, 32'h3000);
    chk("first_ins", out_ins, 32'h2408_0001);
    chk("next_req", {31'b0, im_req}, 32'd1);
    chk("next_addr", im_addr, 32'h3004);
    tick(); out_ready = 1'b1;
    neg();
    tick(); out_ready = 1'b0;
    neg();
    chk("first_drained", {31'b0, out_valid}, 32'd0);

    // fill to DEPTH with a stalled consumer
    tick(); redirect = 1'b1; redirect_pc = 32'h3000;
    neg();
    chk("redir_req", {31'b0, im_req}, 32'd0);
    tick(); redirect = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back({32'h3000 + 32'(4 * k), 32'hC0DE_3000 + 32'(4 * k)});
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      neg();
      if (im_req && im_gnt) grants++;
      tick();
    end
    neg();
    chk("full_grants", 32'(grants), 32'd4);
    chk("full_req", {31'b0, im_req}, 32'd0);
    chk("full_addr", im_addr, 32'h3010);
    chk("full_head_pc", out_pc, 32'h3000);
    tick(); out_ready = 1'b1;
    neg();
    tick(); out_ready = 1'b0;
    sb.push_back({32'h3010, 32'hC0DE_3010});
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      neg();
      if (im_req && im_gnt) grants++;
      tick();
    end
    neg();
    chk("refill_grants", 32'(grants), 32'd1);
    chk("refill_req", {31'b0, im_req}, 32'd0);
    chk("refill_addr", im_addr, 32'h3014);
    tick(); gnt_en = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      neg();
      tick();
    end
    out_ready = 1'b0;
    neg();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    // redirect while waiting, response arrives a cycle later
    tick(); gnt_en = 1'b1; resp_en = 1'b0;
    neg();
    chk("g_req", {31'b0, im_req}, 32'd1);
    chk("g_addr", im_addr, 32'h3014);
    tick(); gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h3043;
    neg();
    chk("h_req", {31'b0, im_req}, 32'd0);
    tick(); redirect = 1'b0; inject = 1'b1; inject_data = 32'hDEAD_BEEF;
    neg();
    chk("drop_req", {31'b0, im_req}, 32'd0);
    tick(); inject = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
    neg();
    chk("drop_valid", {31'b0, out_valid}, 32'd0);
    chk("drop_req_after", {31'b0, im_req}, 32'd1);
    chk("drop_addr", im_addr, 32'h3040);

    // redirect coincident with the response
    tick(); gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h3080;
    neg();
    chk("coinc_req", {31'b0, im_req}, 32'd0);
    tick(); redirect = 1'b0; gnt_en = 1'b1;
    for (int k = 0; k < 12; k++) sb.push_back({32'h3080 + 32'(4 * k), 32'hC0DE_3080 + 32'(4 * k)});
    neg();
    chk("coinc_valid", {31'b0, out_valid}, 32'd0);
    chk("coinc_req_after", {31'b0, im_req}, 32'd1);
    chk("coinc_addr", im_addr, 32'h3080);

    // fill, then stream enqueue+dequeue across several pointer wraps
    for (int i = 0; i < 9; i++) begin
      neg();
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 2 == 0);
      neg();
      chk("wrap_valid", {31'b0, out_valid}, 32'd1);
      tick();
    end
    gnt_en = 1'b0; out_ready = 1'b0;
    neg();
    tick(); out_ready = 1'b1;
    repeat (4) begin
      neg();
      tick();
    end
    out_ready = 1'b0;
    neg();
    chk("wrap_empty", {31'b0, out_valid}, 32'd0);

    // reset in WAIT, stale response after release
    tick(); gnt_en = 1'b1; resp_en = 1'b0;
    neg();
    chk("m_req", {31'b0, im_req}, 32'd1);
    chk("m_addr", im_addr, 32'h30B0);
    tick(); gnt_en = 1'b0; reset = 1'b0;
    #1;
    chk("areset_req", {31'b0, im_req}, 32'd0);
    chk("areset_valid", {31'b0, out_valid}, 32'd0);
    neg();
    chk("areset_addr", im_addr, 32'h3000);
    tick(); reset = 1'b1; inject = 1'b1; inject_data = 32'hBAD0_BAD0;
    neg();
    tick(); inject = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
    sb.push_back({32'h3000, 32'hC0DE_3000});
    neg();
    chk("stale_valid", {31'b0, out_valid}, 32'd0);
    chk("stale_req", {31'b0, im_req}, 32'd1);
    chk("stale_addr", im_addr, 32'h3000);
    tick(); gnt_en = 1'b0;
    neg();
    tick(); out_ready = 1'b1;
    neg();
    chk("post_reset_valid", {31'b0, out_valid}, 32'd1);
    chk("post_reset_pc", out_pc, 32'h3000);
    tick(); out_ready = 1'b0;
    neg();
    chk("end_valid", {31'b0, out_valid}, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000: first fetch address after reset.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port redirect  input  1: D-stage taken branch/jump; flushes queue.
REQ-006 SHALL have port redirect_pc  input  32: new fetch address; bits [1:0] ignored.
REQ-007 SHALL have port im_req  output  1: instruction memory request valid.
REQ-008 SHALL have port im_addr  output  32: request word address, bits [1:0] = 0.
REQ-009 SHALL have port im_gnt  input  1: request accepted this cycle when im_req=1.
REQ-010 SHALL have port im_rvalid  input  1: response data valid; in-order, latency >= 1 cycle after grant.
REQ-011 SHALL have port im_rdata  input  32: instruction word.
REQ-012 SHALL have port out_valid  output  1: head entry valid for the D-stage register.
REQ-013 SHALL have port out_ins  output  32: head instruction.
REQ-014 SHALL have port out_pc  output  32: head instruction address.
REQ-015 SHALL have port out_ready  input  1: consumer accepts head (driven as ~stallID).

Function
REQ-016 SHALL hold fetch PC fpc; im_addr = {fpc[31:2],2'b00}; fpc += 4 on im_req & im_gnt.
REQ-017 SHALL implement states IDLE (no outstanding), WAIT (one outstanding), DROP (outstanding to discard).
REQ-018 SHALL assert im_req only in IDLE, with redirect=0, and count < DEPTH (slot reserved for the outstanding word).
REQ-019 SHALL transition IDLE->WAIT on im_req & im_gnt; IDLE with im_gnt=0 holds im_req/im_addr stable.
REQ-020 SHALL, in WAIT on im_rvalid, enqueue {im_addr of the granted request, im_rdata} at tail and go to IDLE; no new request that cycle.
REQ-021 SHALL ignore im_rvalid in IDLE (no enqueue, no state change).
REQ-022 SHALL present out_valid = (count != 0); out_ins/out_pc = head entry, combinational from storage.
REQ-023 SHALL dequeue head when out_valid & out_ready; enqueue+dequeue same cycle leaves count unchanged.
REQ-024 SHALL wrap head/tail pointers modulo DEPTH; count range 0..DEPTH.
REQ-025 SHALL, on redirect, in the same edge: clear count and pointers, set fpc = {redirect_pc[31:2],2'b00}, suppress enqueue and dequeue.
REQ-026 SHALL, on redirect: IDLE->IDLE; WAIT with im_rvalid=1 ->IDLE (data discarded); WAIT with im_rvalid=0 ->DROP; DROP->DROP, or IDLE if im_rvalid=1.
REQ-027 SHALL, in DROP without redirect, discard response on im_rvalid and go to IDLE; im_req=0 while in DROP.
REQ-028 SHALL give redirect priority over every other event in the same cycle.
REQ-029 SHALL have minimum latency of 2 cycles from grant to out_valid (grant edge, response edge).

Reset
REQ-030 SHALL, while reset=0, asynchronously force state=IDLE, fpc=RESET_PC, count=0, pointers=0, out_valid=0, im_req=0.
REQ-031 SHALL, on reset release, assert im_req with im_addr=RESET_PC in the first cycle; reset mid-WAIT discards any later response arriving in IDLE.

Verification
REQ-032 SHALL verify reset release, im_gnt=1, im_rvalid one cycle later with 32'h2408_0001 -> out_valid=1, out_pc=32'h3000, out_ins=32'h2408_0001; next im_addr=32'h3004.
REQ-033 SHALL verify out_ready=0 with always-ready memory -> exactly DEPTH=4 entries (PCs 3000..300C), then im_req=0; one dequeue -> one request issued.
REQ-034 SHALL verify redirect=1, redirect_pc=32'h3043 in WAIT, response next cycle -> response dropped, out_valid=0, next im_addr=32'h3040.
REQ-035 SHALL verify redirect with im_rvalid=1 in the same cycle -> no enqueue, state IDLE, im_req=1 with im_addr=redirect target next cycle.
REQ-036 SHALL verify queue full with simultaneous dequeue and enqueue over pointer wrap -> count stays 4, PC order strictly +4, no entry lost or duplicated.
REQ-037 SHALL verify reset=0 asserted mid-WAIT -> outputs zero immediately; late im_rvalid after release ignored; first out_pc=32'h3000.
